lower_tri_inverse: RTL and testbench
====================================

// Module: lower_tri_inverse
// PURPOSE
//   Downstream consumer of the LU decomposition stage: takes its unit-lower-triangular L_out and
//   computes X = L^-1 by column-wise forward substitution, one multiply-accumulate per cycle.
//   X feeds the final product stage, which forms A^-1 = U^-1 * L^-1.
//   Uses the same packed row-major matrix bus and start/done handshake as the LU stage.
// PARAMETERS
//   N  4   matrix dimension (N >= 2)
//   W  32  element width; signed two's-complement integer
// PORTS
//   clk       in   1      single clock, all state on rising edge
//   rst       in   1      asynchronous, active-low reset
//   start     in   1      request; sampled only in IDLE or DONE
//   L_in      in   N*N*W  L matrix; element (r,c) at [(r*N+c)*W +: W]
//   busy      out  1      high from the accepting edge until the edge that raises done
//   done      out  1      level; high while a valid result is held
//   Linv_out  out  N*N*W  X = L^-1, same packing as L_in
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, done=0, busy=0, Linv_out=0, all internal regs cleared.
//     Reset mid-computation aborts it; no partial result is ever presented.
//   - Input interpretation: diagonal is treated as 1 and upper triangle as 0; those bits of
//     L_in are ignored. L_in is captured into an internal register on the accepting edge and
//     may change afterwards.
//   - FSM: IDLE -> LOAD -> (MAC^(i-j) -> WRITE) for each (i,j) -> DONE.
//     IDLE : start=1 -> capture L_in, busy=1, go LOAD.
//     LOAD : X <= identity, acc <= 0, j=0, i=1, k=0; go MAC.
//     MAC  : acc <= acc + L[i][k]*X[k][j]; k++; when k==i-1 go WRITE.
//     WRITE: X[i][j] <= -acc (low W bits); acc <= 0; advance i (then j); k <= j of new (i,j);
//            after (N-1,N-2) go DONE.
//     DONE : Linv_out <= X, done=1, busy=0 (same edge). start=1 -> behaves as in IDLE,
//            done drops on the accepting edge, Linv_out holds old value until next done.
//   - Order: j = 0..N-2 outer, i = j+1..N-1 inner, k = j..i-1 innermost.
//   - Latency (N=4): 1 LOAD + 10 MAC + 6 WRITE edges; done rises on the 17th edge after the
//     accepting edge. In general: 1 + sum_{d=1}^{N-1}(N-d)*d + N(N-1)/2.
//   - Arithmetic: signed W x W -> 2W product, 2W accumulator, wraps silently; result = low W
//     bits of two's-complement negation. No overflow flag.
//   - start while busy: ignored (no queueing). start held high in DONE restarts every time.
//   - Linv_out changes only on the edge that raises done (or on reset).
// STRUCTURE
//   - Package lu_pkg: N, W, bus-width localparam N*N*W, function idx(r,c)=r*N+c, state enum
//     {IDLE,LOAD,MAC,WRITE,DONE}; shared with the LU stage and the product stage.
//   - One sub-module: tri_mac (signed W x W multiply into 2W accumulator, clear/enable inputs).
//   - i/j/k counters and X register file stay in the top module.
// TESTING
//   1. L = identity, start -> done after 17 cycles; Linv_out = identity; busy high exactly 17
//      cycles.
//   2. L rows [1 0 0 0][2 1 0 0][0 3 1 0][0 0 4 1] -> Linv rows
//      [1 0 0 0][-2 1 0 0][6 -3 1 0][-24 12 -4 1].
//   3. Same L as test 2, but diagonal set to 7 and upper triangle set to 0xDEADBEEF
//      -> identical result to test 2.
//   4. Strictly-lower all ones -> rows [1 0 0 0][-1 1 0 0][0 -1 1 0][0 0 -1 1].
//   5. Pulse start again at cycle 5 of busy with different L_in -> ignored; result equals the
//      first L. Then start in DONE with test-4 L -> done drops next edge, old Linv_out holds,
//      and the new result appears 17 edges later.
//   6. Assert rst at cycle 8 of a run -> done=0, busy=0, Linv_out=0 immediately (async).
//      Next start gives a correct full result.

Source files
------------

// File: rtl/lu_pkg.sv
// rtl/lu_pkg.sv - shared sizing, bus indexing and FSM states for the LU / inverse / product stages
package lu_pkg;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int BUS_W = N * N * W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        WRITE,
        DONE
    } state_t;

    function automatic int idx(input int r, input int c);
        return r * N + c;
    endfunction

endpackage

// File: rtl/tri_mac.sv
// rtl/tri_mac.sv - signed W x W multiply into a wrapping 2W accumulator with clear/enable
module tri_mac #(
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] acc
);

    logic signed [2*W-1:0] a_ext;
    logic signed [2*W-1:0] b_ext;
    logic signed [2*W-1:0] prod;

    // Low 2W bits of the 2W x 2W product equal the exact signed W x W product.
    assign a_ext = {{W{a[W-1]}}, a};
    assign b_ext = {{W{b[W-1]}}, b};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod;
        end
    end

endmodule

// File: rtl/lower_tri_inverse.sv
// rtl/lower_tri_inverse.sv - X = L^-1 of a unit-lower-triangular matrix by column-wise forward substitution
module lower_tri_inverse
    import lu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BUS_W-1:0] L_in,
    output logic             busy,
    output logic             done,
    output logic [BUS_W-1:0] Linv_out
);

    localparam int IW = (N > 2) ? $clog2(N) : 1;

    state_t state, state_nx;

    logic signed [W-1:0]   l_mem [N][N];
    logic signed [W-1:0]   x_mem [N][N];
    logic [IW-1:0]         i_q, j_q, k_q;
    logic                  accept, mac_en, mac_clr;
    logic                  last_k, last_i, last_pair;
    logic signed [W-1:0]   op_a, op_b;
    logic signed [2*W-1:0] acc, neg_acc;

    assign last_k    = (k_q == i_q - 1'b1);
    assign last_i    = (i_q == IW'(N - 1));
    assign last_pair = last_i && (j_q == IW'(N - 2));
    assign op_a      = l_mem[i_q][k_q];
    assign op_b      = x_mem[k_q][j_q];
    assign neg_acc   = -acc;

    tri_mac #(.W(W)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (op_a),
        .b   (op_b),
        .acc (acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        mac_en   = 1'b0;
        mac_clr  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                mac_clr  = 1'b1;
                state_nx = MAC;
            end
            MAC: begin
                mac_en = 1'b1;
                if (last_k) state_nx = WRITE;
            end
            WRITE: begin
                mac_clr  = 1'b1;
                state_nx = last_pair ? DONE : MAC;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            Linv_out <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    l_mem[r][c] <= '0;
                    x_mem[r][c] <= '0;
                end
            end
        end else begin
            if (accept) begin
                busy <= 1'b1;
                done <= 1'b0;
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        l_mem[r][c] <= L_in[idx(r, c)*W +: W];
                    end
                end
            end
            case (state)
                LOAD: begin
                    i_q <= IW'(1);
                    j_q <= '0;
                    k_q <= '0;
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            x_mem[r][c] <= (r == c) ? W'(1) : '0;
                        end
                    end
                end
                MAC: k_q <= k_q + 1'b1;
                WRITE: begin
                    x_mem[i_q][j_q] <= neg_acc[W-1:0];
                    if (last_pair) begin
                        // The final element is written this same edge, so bypass it into the output.
                        busy <= 1'b0;
                        done <= 1'b1;
                        for (int r = 0; r < N; r++) begin
                            for (int c = 0; c < N; c++) begin
                                Linv_out[idx(r, c)*W +: W] <= (r == N - 1 && c == N - 2)
                                                              ? neg_acc[W-1:0] : x_mem[r][c];
                            end
                        end
                    end else if (last_i) begin
                        j_q <= j_q + 1'b1;
                        i_q <= j_q + IW'(2);
                        k_q <= j_q + 1'b1;
                    end else begin
                        i_q <= i_q + 1'b1;
                        k_q <= j_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lower_tri_inverse.sv
// tb/tb_lower_tri_inverse.sv - scoreboard bench for lower_tri_inverse against a forward-substitution model
module tb_lower_tri_inverse;
    import lu_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [BUS_W-1:0] L_in = '0;
    logic             busy, done;
    logic [BUS_W-1:0] Linv_out;

    int               n_checks = 0;
    int               n_fail = 0;
    logic [BUS_W-1:0] exp_q[$];
    logic             done_d = 1'b0;

    always #5 clk = ~clk;

    lower_tri_inverse dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .L_in     (L_in),
        .busy     (busy),
        .done     (done),
        .Linv_out (Linv_out)
    );

    task automatic check(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int el(input logic [BUS_W-1:0] m, input int r, input int c);
        return $signed(m[(r*N+c)*W +: W]);
    endfunction

    function automatic logic [BUS_W-1:0] pack(input int m[N][N]);
        logic [BUS_W-1:0] v;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                v[(r*N+c)*W +: W] = m[r][c];
        return v;
    endfunction

    // Solve L*X = I column by column; only the strictly-lower part of L takes part.
    function automatic logic [BUS_W-1:0] ref_inv(input logic [BUS_W-1:0] l);
        int     x[N][N];
        longint acc;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                x[r][c] = (r == c) ? 1 : 0;
        for (int j = 0; j < N - 1; j++) begin
            for (int i = j + 1; i < N; i++) begin
                acc = 0;
                for (int k = j; k < i; k++)
                    acc += longint'(el(l, i, k)) * longint'(x[k][j]);
                x[i][j] = int'(-acc);
            end
        end
        return pack(x);
    endfunction

    function automatic logic [BUS_W-1:0] rand_l(input int lim);
        logic [BUS_W-1:0] v;
        for (int e = 0; e < N * N; e++)
            v[e*W +: W] = (lim == 0) ? W'($urandom()) : W'($urandom_range(0, 2 * lim) - lim);
        return v;
    endfunction

    always @(negedge clk) begin
        if (done && !done_d) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                check("result", Linv_out, exp_q.pop_front());
            end
        end
        done_d = done;
    end

    task automatic issue(input logic [BUS_W-1:0] l);
        @(negedge clk);
        L_in  = l;
        start = 1'b1;
        exp_q.push_back(ref_inv(l));
        @(posedge clk);
        #1;
        start = 1'b0;
        L_in  = rand_l(0);
    endtask

    task automatic wait_done(output int cyc);
        bit found = 1'b0;
        cyc = 0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (done) found = 1'b1;
            else if (busy) cyc++;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: got no done within 100 cycles expected done");
        end
    endtask

    initial begin
        int               cyc;
        int               m_id[N][N], m2[N][N], e2[N][N], m4[N][N], e4[N][N];
        logic [BUS_W-1:0] l_id, l2, l3, l4, x2, x4, old;

        m_id = '{'{1,0,0,0}, '{0,1,0,0}, '{0,0,1,0}, '{0,0,0,1}};
        m2   = '{'{1,0,0,0}, '{2,1,0,0}, '{0,3,1,0}, '{0,0,4,1}};
        e2   = '{'{1,0,0,0}, '{-2,1,0,0}, '{6,-3,1,0}, '{-24,12,-4,1}};
        m4   = '{'{1,0,0,0}, '{1,1,0,0}, '{1,1,1,0}, '{1,1,1,1}};
        e4   = '{'{1,0,0,0}, '{-1,1,0,0}, '{0,-1,1,0}, '{0,0,-1,1}};
        l_id = pack(m_id);
        l2   = pack(m2);
        x2   = pack(e2);
        l4   = pack(m4);
        x4   = pack(e4);
        l3   = l2;
        for (int r = 0; r < N; r++)
            for (int c = r; c < N; c++)
                l3[(r*N+c)*W +: W] = (r == c) ? W'(7) : W'(32'hDEADBEEF);

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_linv", Linv_out, 0);
        rst = 1'b1;

        issue(l_id);
        wait_done(cyc);
        check("t1_busy_cycles", cyc, 17);
        check("t1_identity", Linv_out, l_id);

        issue(l2);
        wait_done(cyc);
        check("t2_linv", Linv_out, x2);

        issue(l3);
        wait_done(cyc);
        check("t3_ignored_bits", Linv_out, x2);

        issue(l4);
        wait_done(cyc);
        check("t4_linv", Linv_out, x4);

        issue(l2);
        repeat (4) @(negedge clk);
        L_in  = l4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t5_busy_kept", busy, 1);
        wait_done(cyc);
        check("t5_start_ignored", Linv_out, x2);
        old = Linv_out;
        issue(l4);
        check("t5_done_drops", done, 0);
        check("t5_linv_holds", Linv_out, old);
        wait_done(cyc);
        check("t5_restart_cycles", cyc, 17);
        check("t5_restart_linv", Linv_out, x4);

        issue(l2);
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_linv", Linv_out, 0);
        @(negedge clk);
        rst = 1'b1;
        issue(l4);
        wait_done(cyc);
        check("t6_after_reset", Linv_out, x4);

        for (int n = 0; n < 8; n++) begin
            issue(rand_l((n < 4) ? 3 : 0));
            wait_done(cyc);
            check("rand_cycles", cyc, 17);
        end

        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
